// File: rtl/clkdiv_gen.sv
// Multi-channel divided-clock generator with per-level LFSR jitter, shadowed
// configuration and glitch-free enable/disable.
module clkdiv_gen #(
  parameter int unsigned       NUM_CH    = 2,
  parameter int unsigned       DIV_W     = 8,
  parameter int unsigned       JITTER_W  = 2,
  parameter logic [DIV_W-1:0]  DIV_RST   = '0,
  parameter logic [15:0]       LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            en,
  input  logic                         cfg_load,
  input  logic [NUM_CH*DIV_W-1:0]      div_in,
  input  logic [NUM_CH*JITTER_W-1:0]   jit_mask_in,
  output logic [NUM_CH-1:0]            clk_out,
  output logic [NUM_CH-1:0]            tick,
  output logic [NUM_CH-1:0]            running
);

  localparam int unsigned CW = DIV_W + JITTER_W + 1;

  typedef enum logic [1:0] {OFF, RUN_LO, RUN_HI, DRAIN} state_t;

  logic [15:0]                      lfsr;
  logic [NUM_CH-1:0][DIV_W-1:0]     div_sh;
  logic [NUM_CH-1:0][JITTER_W-1:0]  mask_sh;

  // Galois form of x^16+x^14+x^13+x^11+1, free-running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= LFSR_SEED;
      div_sh  <= {NUM_CH{DIV_RST}};
      mask_sh <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (cfg_load) begin
        div_sh  <= div_in;
        mask_sh <= jit_mask_in;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt, reload, reload_nj;
    logic [JITTER_W-1:0]  jit;
    logic                 out_q, out_nxt, tick_q, tick_nxt;

    always_comb begin
      jit       = lfsr[i*JITTER_W +: JITTER_W] & mask_sh[i];
      reload_nj = CW'(div_sh[i]);
      reload    = CW'(div_sh[i]) + CW'(jit);
      state_nxt = state;
      cnt_nxt   = cnt - CW'(1);
      out_nxt   = out_q;
      tick_nxt  = 1'b0;
      unique case (state)
        OFF: begin
          cnt_nxt = reload_nj;
          out_nxt = 1'b0;
          if (en[i]) state_nxt = RUN_LO;
        end
        RUN_LO: begin
          if (!en[i]) begin
            state_nxt = OFF;
            cnt_nxt   = reload_nj;
          end else if (cnt == '0) begin
            out_nxt   = 1'b1;
            tick_nxt  = 1'b1;
            cnt_nxt   = reload;
            state_nxt = RUN_HI;
          end
        end
        RUN_HI: begin
          if (cnt == '0) begin
            out_nxt   = 1'b0;
            cnt_nxt   = reload;
            state_nxt = RUN_LO;
          end else if (!en[i]) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          // high level always runs to completion; en is ignored here
          if (cnt == '0) begin
            out_nxt   = 1'b0;
            cnt_nxt   = reload_nj;
            state_nxt = OFF;
          end
        end
        default: begin
          state_nxt = OFF;
          out_nxt   = 1'b0;
          cnt_nxt   = reload_nj;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= OFF;
        cnt    <= CW'(DIV_RST);
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        out_q  <= out_nxt;
        tick_q <= tick_nxt;
      end
    end

    assign clk_out[i] = out_q;
    assign tick[i]    = tick_q;
    assign running[i] = (state != OFF);
  end

endmodule

// File: tb/tb_clkdiv_gen.sv
// Scoreboard bench for clkdiv_gen: expected level lengths are queued when
// stimulus is applied and popped as each clk_out level ends.
module tb_clkdiv_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic        cfg_load;
  logic [15:0] div_in;
  logic [3:0]  jit_mask_in;
  logic [1:0]  clk_out, tick, running;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_q [2][$];   // {level value, 16-bit length}
  logic [1:0]  active;
  int          arm_cnt [2];
  logic [7:0]  seen0;
  logic        oor0;
  logic [15:0] lfsr_m;

  clkdiv_gen #(
    .NUM_CH(2), .DIV_W(8), .JITTER_W(2), .DIV_RST(8'd0), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load), .div_in(div_in),
    .jit_mask_in(jit_mask_in), .clk_out(clk_out), .tick(tick), .running(running)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= lfsr_step(lfsr_m);

  task automatic run_monitor();
    int          run [2];
    logic        last [2];
    int          arm_seen [2];
    logic [16:0] e;
    run = '{0, 0}; last = '{1'b0, 1'b0}; arm_seen = '{0, 0};
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (arm_cnt[c] != arm_seen[c]) begin
          arm_seen[c] = arm_cnt[c];
          run[c] = 0;
          last[c] = 1'b0;
          if (c == 0) begin seen0 = '0; oor0 = 1'b0; end
        end else if (active[c]) begin
          if (clk_out[c] !== last[c]) begin
            total++;
            if (exp_q[c].size() == 0) begin
              bad++;
              $display("FAIL level_ch%0d: got end of level=%0b after %0d cycles, want no transition",
                       c, last[c], run[c]);
            end else begin
              e = exp_q[c].pop_front();
              if ({last[c], 16'(run[c])} !== e) begin
                bad++;
                $display("FAIL level_ch%0d: got level=%0b len=%0d, want level=%0b len=%0d",
                         c, last[c], run[c], e[16], e[15:0]);
              end
            end
            if (c == 0) begin
              if (run[c] >= 3 && run[c] <= 6) seen0[run[c]] = 1'b1;
              else oor0 = 1'b1;
            end
            total++;
            if (tick[c] !== clk_out[c]) begin
              bad++;
              $display("FAIL tick_edge_ch%0d: got tick=%b, want %b", c, tick[c], clk_out[c]);
            end
            last[c] = clk_out[c];
            run[c] = 1;
          end else begin
            run[c]++;
            total++;
            if (tick[c] !== 1'b0) begin
              bad++;
              $display("FAIL tick_flat_ch%0d: got tick=%b, want 0", c, tick[c]);
            end
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    active = '0; en = '0; cfg_load = 1'b0; div_in = '0; jit_mask_in = '0;
    exp_q[0].delete(); exp_q[1].delete();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Ends 2 time units after a posedge, with the new shadows already in use.
  task automatic load_cfg(input logic [7:0] d1, input logic [7:0] d0, input logic [3:0] m);
    div_in = {d1, d0}; jit_mask_in = m; cfg_load = 1'b1;
    @(posedge clk); #2 cfg_load = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic arm(input int c);
    arm_cnt[c]++;
    active[c] = 1'b1;
  endtask

  task automatic wait_q(input int c, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (exp_q[c].size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0; en = '0; cfg_load = 1'b0; div_in = '0; jit_mask_in = '0; active = '0;
    #1;
    total++;
    if ({clk_out, tick, running} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got clk_out=%b tick=%b running=%b, want all 0", clk_out, tick, running);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({clk_out, running} !== 4'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got clk_out=%b running=%b, want 00 00", clk_out, running);
    end
    ok = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    apply_reset();
    load_cfg(8'd3, 8'd0, 4'b0000);
    for (int k = 0; k < 12; k++) exp_q[0].push_back({k[0], 16'd1});
    for (int k = 0; k < 6; k++)  exp_q[1].push_back({k[0], 16'd4});
    en = 2'b11; arm(0); arm(1);
    @(posedge clk); @(negedge clk);
    total++;
    if (running !== 2'b11) begin
      bad++;
      $display("FAIL basic_running: got %b, want 11", running);
    end
    wait_q(0, 100, ok);
    active[0] = 1'b0; en[0] = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL basic_ch0_timeout: got %0d pending, want 0", exp_q[0].size()); end
    wait_q(1, 100, ok);
    active[1] = 1'b0; en[1] = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL basic_ch1_timeout: got %0d pending, want 0", exp_q[1].size()); end
  endtask

  task automatic test_disable();
    bit ok;
    apply_reset();
    load_cfg(8'd0, 8'd4, 4'b0000);
    exp_q[0].push_back({1'b0, 16'd5});
    exp_q[0].push_back({1'b1, 16'd5});
    en[0] = 1'b1; arm(0);
    repeat (7) @(posedge clk);
    #2 en[0] = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++;
    if ({clk_out[0], running[0]} !== 2'b11) begin
      bad++;
      $display("FAIL drain_high: got clk_out=%b running=%b, want 1 1", clk_out[0], running[0]);
    end
    wait_q(0, 50, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL drain_timeout: got %0d pending, want 0", exp_q[0].size()); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if ({clk_out[0], tick[0], running[0]} !== 3'b000) begin
        bad++;
        $display("FAIL drained_quiet: got clk_out=%b tick=%b running=%b, want 0 0 0",
                 clk_out[0], tick[0], running[0]);
      end
    end
    en[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if (running[0] !== 1'b1) begin bad++; $display("FAIL low_run: got running=%b, want 1", running[0]); end
    en[0] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      total++;
      if ({clk_out[0], tick[0], running[0]} !== 3'b000) begin
        bad++;
        $display("FAIL low_drop_quiet: got clk_out=%b tick=%b running=%b, want 0 0 0",
                 clk_out[0], tick[0], running[0]);
      end
    end
    active[0] = 1'b0;
  endtask

  task automatic test_reconfig();
    bit ok;
    int lens [10] = '{4, 4, 4, 2, 2, 2, 2, 4, 4, 4};
    apply_reset();
    load_cfg(8'd0, 8'd3, 4'b0000);
    for (int k = 0; k < 10; k++) exp_q[0].push_back({k[0], 16'(lens[k])});
    en[0] = 1'b1; arm(0);
    repeat (10) @(posedge clk);
    #2 div_in[7:0] = 8'd1; cfg_load = 1'b1;
    @(posedge clk); #2 cfg_load = 1'b0;
    repeat (7) @(posedge clk);
    #2 div_in[7:0] = 8'd3; cfg_load = 1'b1;
    @(posedge clk); #2 cfg_load = 1'b0;
    wait_q(0, 100, ok);
    active[0] = 1'b0; en[0] = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL reconfig_timeout: got %0d pending, want 0", exp_q[0].size()); end
  endtask

  task automatic test_jitter();
    bit          ok;
    logic [15:0] l;
    int          tnow, tev, len;
    apply_reset();
    load_cfg(8'd0, 8'd2, 4'b0011);
    l = lfsr_m; tnow = 0;
    exp_q[0].push_back({1'b0, 16'd3});
    tev = 3;
    for (int n = 1; n < 2000; n++) begin
      while (tnow < tev) begin l = lfsr_step(l); tnow++; end
      len = 3 + int'(l[1:0]);
      exp_q[0].push_back({n[0], 16'(len)});
      tev += len;
    end
    en[0] = 1'b1; arm(0);
    wait_q(0, 12000, ok);
    active[0] = 1'b0; en[0] = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL jitter_timeout: got %0d pending, want 0", exp_q[0].size()); end
    total++;
    if ({oor0, seen0} !== 9'b0_0111_1000) begin
      bad++;
      $display("FAIL jitter_range: got out_of_range=%b seen=%b, want 0 01111000", oor0, seen0);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    apply_reset();
    load_cfg(8'd0, 8'd4, 4'b0000);
    exp_q[0].push_back({1'b0, 16'd5});
    en[0] = 1'b1; arm(0);
    repeat (7) @(posedge clk);
    #1;
    total++;
    if (clk_out[0] !== 1'b1) begin bad++; $display("FAIL pre_reset_high: got %b, want 1", clk_out[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({clk_out, tick, running} !== 6'b0) begin
      bad++;
      $display("FAIL async_reset: got clk_out=%b tick=%b running=%b, want all 0", clk_out, tick, running);
    end
    active[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if ({clk_out[0], running[0]} !== 2'b00) begin
      bad++;
      $display("FAIL held_reset: got clk_out=%b running=%b, want 0 0", clk_out[0], running[0]);
    end
    exp_q[0].delete();
    for (int k = 0; k < 4; k++) exp_q[0].push_back({k[0], 16'd1});
    @(posedge clk); #2 rst_n = 1'b1; arm(0);
    wait_q(0, 50, ok);
    active[0] = 1'b0; en[0] = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL post_reset_timeout: got %0d pending, want 0", exp_q[0].size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int lens [5] = '{3, 3, 4, 3, 3};
    apply_reset();
    load_cfg(8'd2, 8'd0, 4'b0000);
    for (int k = 0; k < 5; k++) exp_q[1].push_back({k[0], 16'(lens[k])});
    en[1] = 1'b1; arm(1);
    repeat (4) @(posedge clk);
    #2 en[1] = 1'b0;
    @(posedge clk); #2 en[1] = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++;
    if ({clk_out[1], running[1]} !== 2'b00) begin
      bad++;
      $display("FAIL drain_to_off: got clk_out=%b running=%b, want 0 0", clk_out[1], running[1]);
    end
    @(negedge clk);
    total++;
    if (running[1] !== 1'b1) begin bad++; $display("FAIL restart_run: got %b, want 1", running[1]); end
    wait_q(1, 60, ok);
    active[1] = 1'b0; en[1] = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL restart_timeout: got %0d pending, want 0", exp_q[1].size()); end
  endtask

  initial begin
    arm_cnt = '{0, 0};
    active = '0;
    seen0 = '0;
    oor0 = 1'b0;
    fork
      run_monitor();
    join_none
    test_reset();
    test_basic();
    test_disable();
    test_reconfig();
    test_jitter();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
